// File: rtl/uart_led_cmd_master_pkg.sv
// Shared definitions for the UART LED-command initiator: command nibbles,
// error codes, FSM state encoding and the command byte encoder.
package uart_led_cmd_master_pkg;

    localparam logic [3:0] CMD_ON_NIB  = 4'hF;
    localparam logic [3:0] CMD_OFF_NIB = 4'hA;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b01;
    localparam logic [1:0] ERR_MISMATCH = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND      = 2'd1,
        ST_WAIT_ECHO = 2'd2,
        ST_FINISH    = 2'd3
    } state_t;

    function automatic logic [7:0] encode_cmd(input logic on, input logic [1:0] led);
        return {(on ? CMD_ON_NIB : CMD_OFF_NIB), 2'b00, led};
    endfunction

endpackage

// File: rtl/uart_led_cmd_master_echo_timer.sv
// Saturating cycle counter bounding how long one attempt waits for its echo.
// expired is high while the count sits at its last value.
module uart_led_cmd_master_echo_timer #(
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != LAST)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == LAST);

endmodule

// File: rtl/uart_led_cmd_master.sv
// Host-side LED command initiator: sends one command byte, waits for its echo,
// retries on mismatch/timeout and keeps a shadow of the remote LED state.
module uart_led_cmd_master
    import uart_led_cmd_master_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 200000,
    parameter int MAX_RETRY      = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_led,
    input  logic       cmd_on,
    output logic [7:0] tx_data,
    output logic       tx_go,
    input  logic       tx_done,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code,
    output logic [3:0] led_state
);

    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

    state_t        state_q, state_d;
    logic [7:0]    cmd_byte_q, cmd_byte_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [3:0]    led_state_q, led_state_d;
    logic          tx_go_q, tx_go_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          err_q, err_d;
    logic [1:0]    err_code_q, err_code_d;

    logic          timer_expired;
    logic          fail;
    logic [1:0]    fail_code;

    uart_led_cmd_master_echo_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_echo_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (state_q == ST_SEND),
        .enable (state_q == ST_WAIT_ECHO),
        .expired(timer_expired)
    );

    always_comb begin
        state_d     = state_q;
        cmd_byte_d  = cmd_byte_q;
        retry_d     = retry_q;
        led_state_d = led_state_q;
        tx_go_d     = tx_go_q;
        tx_data_d   = tx_data_q;
        err_d       = 1'b0;
        err_code_d  = err_code_q;
        fail        = 1'b0;
        fail_code   = ERR_NONE;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    cmd_byte_d = encode_cmd(cmd_on, cmd_led);
                    tx_data_d  = encode_cmd(cmd_on, cmd_led);
                    retry_d    = '0;
                    tx_go_d    = 1'b1;
                    state_d    = ST_SEND;
                end
            end
            ST_SEND: begin
                if (tx_done) begin
                    tx_go_d = 1'b0;
                    state_d = ST_WAIT_ECHO;
                end
            end
            ST_WAIT_ECHO: begin
                // An echo arriving on the expiry cycle takes precedence over the timeout.
                if (rx_done) begin
                    if (rx_data == cmd_byte_q) begin
                        state_d = ST_FINISH;
                    end else begin
                        fail      = 1'b1;
                        fail_code = ERR_MISMATCH;
                    end
                end else if (timer_expired) begin
                    fail      = 1'b1;
                    fail_code = ERR_TIMEOUT;
                end

                if (fail) begin
                    if (retry_q < RETRY_LIMIT) begin
                        retry_d = retry_q + 1'b1;
                        tx_go_d = 1'b1;
                        state_d = ST_SEND;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = fail_code;
                        state_d    = ST_IDLE;
                    end
                end
            end
            ST_FINISH: begin
                led_state_d[cmd_byte_q[1:0]] = (cmd_byte_q[7:4] == CMD_ON_NIB);
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cmd_byte_q  <= 8'h00;
            retry_q     <= '0;
            led_state_q <= 4'h0;
            tx_go_q     <= 1'b0;
            tx_data_q   <= 8'h00;
            err_q       <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            cmd_byte_q  <= cmd_byte_d;
            retry_q     <= retry_d;
            led_state_q <= led_state_d;
            tx_go_q     <= tx_go_d;
            tx_data_q   <= tx_data_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = ~cmd_ready;
    assign done      = (state_q == ST_FINISH);
    assign err       = err_q;
    assign err_code  = err_code_q;
    assign tx_go     = tx_go_q;
    assign tx_data   = tx_data_q;
    assign led_state = led_state_q;

endmodule

// File: tb/tb_uart_led_cmd_master.sv
// Directed bench for uart_led_cmd_master: transmitter/receiver behaviour is
// driven by hand-timed tasks, outputs sampled on the falling edge.
module tb_uart_led_cmd_master;

    logic       clk;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_led;
    logic       cmd_on;
    logic [7:0] tx_data;
    logic       tx_go;
    logic       tx_done;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       busy;
    logic       done;
    logic       err;
    logic [1:0] err_code;
    logic [3:0] led_state;

    int pass_cnt  = 0;
    int check_cnt = 0;
    int done_cnt  = 0;
    int err_cnt   = 0;
    int both_cnt  = 0;
    int frame_cnt = 0;
    logic tx_go_prev = 1'b0;

    uart_led_cmd_master #(
        .TIMEOUT_CYCLES(100),
        .MAX_RETRY     (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_led  (cmd_led),
        .cmd_on   (cmd_on),
        .tx_data  (tx_data),
        .tx_go    (tx_go),
        .tx_done  (tx_done),
        .rx_data  (rx_data),
        .rx_done  (rx_done),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .err_code (err_code),
        .led_state(led_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse/frame monitor, sampled just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (done === 1'b1) done_cnt++;
        if (err === 1'b1) err_cnt++;
        if (done === 1'b1 && err === 1'b1) both_cnt++;
        if (tx_go === 1'b1 && tx_go_prev === 1'b0) frame_cnt++;
        tx_go_prev = tx_go;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_cmd(input logic [1:0] led, input logic on);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_led   = led;
        cmd_on    = on;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_tx_go(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (tx_go === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic pulse_tx_done(input int n);
        repeat (n) @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    task automatic rx_pulse(input logic [7:0] b, input int m);
        repeat (m) @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        cmd_valid = 1'b1;
        cmd_led   = 2'd1;
        cmd_on    = 1'b1;
        tx_done   = 1'b0;
        rx_done   = 1'b0;
        rx_data   = 8'h00;
        repeat (3) @(negedge clk);
        check_cnt++; if (cmd_ready !== 1'b1) $display("FAIL rst_cmd_ready got=%0b exp=1", cmd_ready); else pass_cnt++;
        check_cnt++; if (tx_go !== 1'b0) $display("FAIL rst_tx_go got=%0b exp=0", tx_go); else pass_cnt++;
        check_cnt++; if (tx_data !== 8'h00) $display("FAIL rst_tx_data got=%h exp=00", tx_data); else pass_cnt++;
        check_cnt++; if ({done, err, err_code} !== 4'b0000) $display("FAIL rst_done_err got=%b exp=0000", {done, err, err_code}); else pass_cnt++;
        check_cnt++; if (led_state !== 4'h0) $display("FAIL rst_led_state got=%h exp=0", led_state); else pass_cnt++;
        reset     = 1'b0;
        cmd_valid = 1'b0;
        @(negedge clk);
        check_cnt++; if (tx_go !== 1'b0) $display("FAIL rst_no_accept got=%0b exp=0", tx_go); else pass_cnt++;
        $display("test_reset: outputs at reset values, no accept during reset");
    endtask

    task automatic test_on_cmd();
        int d0 = done_cnt;
        int f0 = frame_cnt;
        send_cmd(2'd2, 1'b1);
        check_cnt++; if (tx_go !== 1'b1) $display("FAIL t1_tx_go got=%0b exp=1", tx_go); else pass_cnt++;
        check_cnt++; if (tx_data !== 8'hF2) $display("FAIL t1_tx_data got=%h exp=f2", tx_data); else pass_cnt++;
        check_cnt++; if ({cmd_ready, busy} !== 2'b01) $display("FAIL t1_ready_busy got=%b exp=01", {cmd_ready, busy}); else pass_cnt++;
        pulse_tx_done(3);
        check_cnt++; if (tx_go !== 1'b0) $display("FAIL t1_tx_go_drop got=%0b exp=0", tx_go); else pass_cnt++;
        rx_pulse(8'hF2, 4);
        check_cnt++; if ({done, err} !== 2'b10) $display("FAIL t1_done got=%b exp=10", {done, err}); else pass_cnt++;
        @(negedge clk);
        check_cnt++; if (done !== 1'b0) $display("FAIL t1_done_one_cycle got=%0b exp=0", done); else pass_cnt++;
        check_cnt++; if (led_state !== 4'b0100) $display("FAIL t1_led_state got=%b exp=0100", led_state); else pass_cnt++;
        check_cnt++; if (cmd_ready !== 1'b1) $display("FAIL t1_ready_after got=%0b exp=1", cmd_ready); else pass_cnt++;
        check_cnt++; if (done_cnt - d0 != 1 || frame_cnt - f0 != 1) $display("FAIL t1_counts got done=%0d frames=%0d exp done=1 frames=1", done_cnt - d0, frame_cnt - f0); else pass_cnt++;
        $display("test_on_cmd: led2 on, byte f2, led_state=%b", led_state);
    endtask

    task automatic test_off_cmd();
        send_cmd(2'd2, 1'b0);
        check_cnt++; if (tx_data !== 8'hA2) $display("FAIL t2_tx_data got=%h exp=a2", tx_data); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            check_cnt++; if (tx_go !== 1'b1) $display("FAIL t2_tx_go_held cyc=%0d got=%0b exp=1", i, tx_go); else pass_cnt++;
            @(negedge clk);
        end
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        check_cnt++; if (tx_go !== 1'b0) $display("FAIL t2_tx_go_drop got=%0b exp=0", tx_go); else pass_cnt++;
        rx_pulse(8'hA2, 2);
        check_cnt++; if (done !== 1'b1) $display("FAIL t2_done got=%0b exp=1", done); else pass_cnt++;
        @(negedge clk);
        check_cnt++; if (led_state !== 4'h0) $display("FAIL t2_led_state got=%b exp=0000", led_state); else pass_cnt++;
        $display("test_off_cmd: led2 off, byte a2, led_state=%b", led_state);
    endtask

    task automatic test_timeout_retry();
        int  d0 = done_cnt;
        int  e0 = err_cnt;
        int  f0 = frame_cnt;
        bit  ok;
        send_cmd(2'd0, 1'b1);
        for (int a = 0; a < 3; a++) begin
            wait_tx_go(ok);
            check_cnt++; if (!ok) $display("FAIL t3_tx_go_wait attempt=%0d got=timeout exp=tx_go", a); else pass_cnt++;
            check_cnt++; if (tx_data !== 8'hF0) $display("FAIL t3_tx_data attempt=%0d got=%h exp=f0", a, tx_data); else pass_cnt++;
            pulse_tx_done(2);
            repeat (99) @(negedge clk);
            check_cnt++; if ({tx_go, err} !== 2'b00) $display("FAIL t3_early attempt=%0d got=%b exp=00", a, {tx_go, err}); else pass_cnt++;
            @(negedge clk);
            if (a < 2) begin
                check_cnt++; if (tx_go !== 1'b1) $display("FAIL t3_retry attempt=%0d got=%0b exp=1", a, tx_go); else pass_cnt++;
            end else begin
                check_cnt++; if ({err, err_code} !== 3'b101) $display("FAIL t3_err got=%b exp=101", {err, err_code}); else pass_cnt++;
                check_cnt++; if ({cmd_ready, tx_go} !== 2'b10) $display("FAIL t3_idle got=%b exp=10", {cmd_ready, tx_go}); else pass_cnt++;
            end
        end
        @(negedge clk);
        check_cnt++; if ({err, err_code} !== 3'b001) $display("FAIL t3_err_pulse_hold got=%b exp=001", {err, err_code}); else pass_cnt++;
        check_cnt++; if (led_state !== 4'h0) $display("FAIL t3_led_state got=%b exp=0000", led_state); else pass_cnt++;
        check_cnt++; if (err_cnt - e0 != 1 || done_cnt - d0 != 0 || frame_cnt - f0 != 3) $display("FAIL t3_counts got err=%0d done=%0d frames=%0d exp 1 0 3", err_cnt - e0, done_cnt - d0, frame_cnt - f0); else pass_cnt++;
        $display("test_timeout_retry: frames=%0d err_code=%b", frame_cnt - f0, err_code);
    endtask

    task automatic test_mismatch_retry();
        int d0 = done_cnt;
        int e0 = err_cnt;
        int f0 = frame_cnt;
        send_cmd(2'd1, 1'b1);
        check_cnt++; if (tx_data !== 8'hF1) $display("FAIL t4_tx_data got=%h exp=f1", tx_data); else pass_cnt++;
        pulse_tx_done(2);
        rx_pulse(8'h55, 3);
        check_cnt++; if ({tx_go, done, err} !== 3'b100) $display("FAIL t4_retry got=%b exp=100", {tx_go, done, err}); else pass_cnt++;
        pulse_tx_done(2);
        rx_pulse(8'hF1, 3);
        check_cnt++; if (done !== 1'b1) $display("FAIL t4_done got=%0b exp=1", done); else pass_cnt++;
        @(negedge clk);
        check_cnt++; if (led_state !== 4'b0010) $display("FAIL t4_led_state got=%b exp=0010", led_state); else pass_cnt++;
        check_cnt++; if (err_cnt - e0 != 0 || done_cnt - d0 != 1 || frame_cnt - f0 != 2) $display("FAIL t4_counts got err=%0d done=%0d frames=%0d exp 0 1 2", err_cnt - e0, done_cnt - d0, frame_cnt - f0); else pass_cnt++;
        $display("test_mismatch_retry: 55 then f1, led_state=%b", led_state);
    endtask

    task automatic test_echo_at_expiry();
        int f0 = frame_cnt;
        int e0 = err_cnt;
        send_cmd(2'd3, 1'b1);
        pulse_tx_done(2);
        repeat (99) @(negedge clk);
        rx_data = 8'hF3;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        check_cnt++; if ({done, err, tx_go} !== 3'b100) $display("FAIL t5_done_no_retry got=%b exp=100", {done, err, tx_go}); else pass_cnt++;
        @(negedge clk);
        check_cnt++; if (led_state !== 4'b1010) $display("FAIL t5_led_state got=%b exp=1010", led_state); else pass_cnt++;
        check_cnt++; if (frame_cnt - f0 != 1 || err_cnt - e0 != 0) $display("FAIL t5_counts got frames=%0d err=%0d exp 1 0", frame_cnt - f0, err_cnt - e0); else pass_cnt++;
        $display("test_echo_at_expiry: echo on expiry cycle accepted");
    endtask

    task automatic test_reset_mid_wait();
        int d0;
        int e0;
        send_cmd(2'd0, 1'b1);
        pulse_tx_done(2);
        repeat (5) @(negedge clk);
        check_cnt++; if (busy !== 1'b1) $display("FAIL t6_busy_before got=%0b exp=1", busy); else pass_cnt++;
        reset = 1'b1;
        @(negedge clk);
        d0 = done_cnt;
        e0 = err_cnt;
        check_cnt++; if ({cmd_ready, busy, tx_go} !== 3'b100) $display("FAIL t6_idle got=%b exp=100", {cmd_ready, busy, tx_go}); else pass_cnt++;
        check_cnt++; if ({tx_data, err_code} !== 10'h000) $display("FAIL t6_data_code got=%h exp=000", {tx_data, err_code}); else pass_cnt++;
        check_cnt++; if ({done, err, led_state} !== 6'b000000) $display("FAIL t6_pulses_leds got=%b exp=000000", {done, err, led_state}); else pass_cnt++;
        reset = 1'b0;
        rx_pulse(8'hF0, 1);
        check_cnt++; if ({cmd_ready, done} !== 2'b10) $display("FAIL t6_stray_rx got=%b exp=10", {cmd_ready, done}); else pass_cnt++;
        repeat (2) @(negedge clk);
        check_cnt++; if (led_state !== 4'h0) $display("FAIL t6_led_after_stray got=%b exp=0000", led_state); else pass_cnt++;
        check_cnt++; if (done_cnt - d0 != 0 || err_cnt - e0 != 0) $display("FAIL t6_no_pulses got done=%0d err=%0d exp 0 0", done_cnt - d0, err_cnt - e0); else pass_cnt++;
        $display("test_reset_mid_wait: command dropped, stray rx ignored");
    endtask

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_led   = 2'd0;
        cmd_on    = 1'b0;
        tx_done   = 1'b0;
        rx_done   = 1'b0;
        rx_data   = 8'h00;
        test_reset();
        test_on_cmd();
        test_off_cmd();
        test_timeout_retry();
        test_mismatch_retry();
        test_echo_at_expiry();
        test_reset_mid_wait();
        check_cnt++; if (both_cnt != 0) $display("FAIL done_err_overlap got=%0d exp=0", both_cnt); else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
